demux_stream_1_n: RTL

Parametrised, registered 1:N packet-stream demultiplexer with valid/ready flow control. It latches the channel select on the first beat of each packet and routes every beat to that channel through a single-entry output register, up to and including the `Last` beat. It is the pipelined, backpressure-aware successor to the combinational 1:8 DEMUX and sits between a packet source and N independent downstream consumers.

---
 rtl/demux_stream_pkg.sv | 25 ++
 rtl/demux_out_slice.sv | 83 ++++++++
 rtl/demux_stream_1_n.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_pkg.sv
// ----------------------------------------------------------------------------
// demux_stream_pkg
// Shared declarations for the demux_stream_1_n packet demultiplexer.
//   - demux_state_e  : packet FSM state (IDLE / PKT / DROP)
//   - DROP_CNT_WIDTH : width of the dropped-packet counter
//   - sel_width()    : select width for a given channel count, never below 1
// ----------------------------------------------------------------------------
package demux_stream_pkg;

  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the first beat of a packet
    ST_PKT  = 2'd1,  // packet open, beats go to the locked channel
    ST_DROP = 2'd2   // packet open, beats are consumed and discarded
  } demux_state_e;

  // $clog2(1) and $clog2(2) differ; a select bus needs at least one bit.
  function automatic int sel_width(input int num_channels);
    int w;
    w = $clog2(num_channels);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_out_slice.sv
// ----------------------------------------------------------------------------
// demux_out_slice
// Single-entry output holding register for the stream demultiplexer. It holds
// one beat (payload, last flag, destination channel) plus a valid bit. The beat
// drains when the downstream ready bit of its own channel is high; a new beat
// may load on the same edge, so the slice sustains one beat per cycle.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset, clears the held beat
//   i_load      load i_data/i_last/i_ch into the register this edge
//   i_data      payload to load
//   i_last      last flag to load
//   i_ch        destination channel to load
//   i_ready     per-channel downstream ready (only the held channel matters)
//   o_data      held payload (keeps its value after draining)
//   o_last      held last flag (keeps its value after draining)
//   o_ch        held channel index
//   o_valid     a beat is held
//   o_can_load  register is empty or drains this edge
// ----------------------------------------------------------------------------
module demux_out_slice #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 8,
  parameter int SEL_WIDTH    = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_last,
  input  logic [SEL_WIDTH-1:0]    i_ch,
  input  logic [NUM_CHANNELS-1:0] i_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_last,
  output logic [SEL_WIDTH-1:0]    o_ch,
  output logic                    o_valid,
  output logic                    o_can_load
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [SEL_WIDTH-1:0]  r_ch;
  logic                  r_valid;
  logic                  w_ready_sel;
  logic                  w_drain;

  // Select the ready bit of the held channel with an explicit compare loop so
  // a non-power-of-two channel count never indexes past the ready vector.
  always_comb begin
    w_ready_sel = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_ch == SEL_WIDTH'(i)) begin
        w_ready_sel = i_ready[i];
      end
    end
  end

  assign w_drain    = r_valid && w_ready_sel;
  assign o_can_load = !r_valid || w_ready_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_ch    <= i_ch;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_ch    = r_ch;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux_stream_1_n.sv
// ----------------------------------------------------------------------------
// demux_stream_1_n
// Registered 1:N packet-stream demultiplexer with valid/ready flow control.
// The channel select is latched on the first beat of each packet; every beat
// up to and including the Last beat is routed to that channel through a
// single-entry output register (demux_out_slice).
//
// Optional feature macro: DEMUX_STREAM_DROP_INVALID_EN
//   defined   : a first beat with an out-of-range select drops the whole packet
//               and bumps Drop_Count_Out (saturating at all ones).
//   undefined : an out-of-range select is clamped to the last channel; the
//               DROP state and the Drop_Count_Out port are absent.
//
// Ports:
//   Clock_In        clock, rising edge
//   Reset_N_In      asynchronous active-low reset
//   Enable_In       permits the start of new packets
//   Data_In         input beat payload
//   Valid_In        input beat valid
//   Last_In         final beat of a packet
//   Select_In       destination channel, sampled on the first beat only
//   Ready_Out       input ready
//   Data_Out        payload bus shared by all channels
//   Last_Out        last flag of the held beat
//   Valid_Out       one-hot per-channel valid
//   Ready_In        per-channel downstream ready
//   Busy_Out        a packet is open
//   Drop_Count_Out  dropped-packet count (macro builds only)
// ----------------------------------------------------------------------------
module demux_stream_1_n
  import demux_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 8,
  localparam int SEL_WIDTH   = sel_width(NUM_CHANNELS)
) (
  input  logic                      Clock_In,
  input  logic                      Reset_N_In,
  input  logic                      Enable_In,
  input  logic [DATA_WIDTH-1:0]     Data_In,
  input  logic                      Valid_In,
  input  logic                      Last_In,
  input  logic [SEL_WIDTH-1:0]      Select_In,
  output logic                      Ready_Out,
  output logic [DATA_WIDTH-1:0]     Data_Out,
  output logic                      Last_Out,
  output logic [NUM_CHANNELS-1:0]   Valid_Out,
  input  logic [NUM_CHANNELS-1:0]   Ready_In,
  output logic                      Busy_Out
`ifdef DEMUX_STREAM_DROP_INVALID_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] Drop_Count_Out
`endif
);

  // One extra bit so NUM_CHANNELS itself is representable for the range check.
  localparam logic [SEL_WIDTH:0]   NUM_CH_EXT = (SEL_WIDTH + 1)'(NUM_CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LAST_CH    = SEL_WIDTH'(NUM_CHANNELS - 1);

  demux_state_e          r_state;
  demux_state_e          w_state_next;
  logic [SEL_WIDTH-1:0]  r_ch_lock;

  logic                  w_sel_in_range;
  logic                  w_deliver_first;  // first beat opens a delivered packet
  logic [SEL_WIDTH-1:0]  w_first_ch;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_load;
  logic [SEL_WIDTH-1:0]  w_load_ch;
  logic                  w_can_load;
  logic                  w_held_valid;
  logic [SEL_WIDTH-1:0]  w_held_ch;

  assign w_sel_in_range = ({1'b0, Select_In} < NUM_CH_EXT);

`ifdef DEMUX_STREAM_DROP_INVALID_EN
  logic                      w_drop_first;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  assign w_deliver_first = w_sel_in_range;
  assign w_first_ch      = Select_In;
`else
  assign w_deliver_first = 1'b1;
  assign w_first_ch      = w_sel_in_range ? Select_In : LAST_CH;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // A single-beat packet opens and closes on the same beat.
        if (w_accept && !Last_In) begin
`ifdef DEMUX_STREAM_DROP_INVALID_EN
          w_state_next = w_deliver_first ? ST_PKT : ST_DROP;
`else
          w_state_next = ST_PKT;
`endif
        end
      end
      ST_PKT: begin
        if (w_accept && Last_In) begin
          w_state_next = ST_IDLE;
        end
      end
`ifdef DEMUX_STREAM_DROP_INVALID_EN
      ST_DROP: begin
        if (w_accept && Last_In) begin
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (input ready, beat acceptance, slice load, drop event)
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready   = 1'b0;
    w_load    = 1'b0;
    w_load_ch = r_ch_lock;
`ifdef DEMUX_STREAM_DROP_INVALID_EN
    w_drop_first = 1'b0;
`endif
    case (r_state)
      ST_IDLE: w_ready = Enable_In && w_can_load;
      ST_PKT:  w_ready = w_can_load;
`ifdef DEMUX_STREAM_DROP_INVALID_EN
      ST_DROP: w_ready = 1'b1;
`endif
      default: w_ready = 1'b0;
    endcase

    w_accept = Valid_In && Reset_N_In && w_ready;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_deliver_first) begin
            w_load    = 1'b1;
            w_load_ch = w_first_ch;
          end
`ifdef DEMUX_STREAM_DROP_INVALID_EN
          else begin
            w_drop_first = 1'b1;
          end
`endif
        end
      end
      ST_PKT: begin
        w_load = w_accept;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Ready is forced low while reset is held, independent of the FSM.
  assign Ready_Out = Reset_N_In && w_ready;
  assign Busy_Out  = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Channel latch: captured on the first beat, reused for the rest of the packet
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_ch_lock <= '0;
    end else if ((r_state == ST_IDLE) && w_load) begin
      r_ch_lock <= w_first_ch;
    end
  end

`ifdef DEMUX_STREAM_DROP_INVALID_EN
  // --------------------------------------------------------------------------
  // Dropped-packet counter: one count per dropped first beat, saturating
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_drop_cnt <= '0;
    end else if (w_drop_first && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign Drop_Count_Out = r_drop_cnt;
`endif

  // --------------------------------------------------------------------------
  // Output holding register
  // --------------------------------------------------------------------------
  demux_out_slice #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_CHANNELS (NUM_CHANNELS),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_out_slice (
    .i_clk      (Clock_In),
    .i_rst_n    (Reset_N_In),
    .i_load     (w_load),
    .i_data     (Data_In),
    .i_last     (Last_In),
    .i_ch       (w_load_ch),
    .i_ready    (Ready_In),
    .o_data     (Data_Out),
    .o_last     (Last_Out),
    .o_ch       (w_held_ch),
    .o_valid    (w_held_valid),
    .o_can_load (w_can_load)
  );

  // --------------------------------------------------------------------------
  // One-hot valid decode of the held channel
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_valid_decode
      assign Valid_Out[gi] = w_held_valid && (w_held_ch == SEL_WIDTH'(gi));
    end
  endgenerate

endmodule
